display_formatter: RTL and testbench

Converts the calculator's signed fixed-point display value (integer count of thousandths) into a sign flag, a decimal-point flag with position, and four packed BCD digits for the seven-segment driver. It sits between the calculator control FSM, which supplies the value and the operand sign mode, and the digit/segment multiplexer. It has two pipeline stages: magnitude/sign extraction, then BCD formatting.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/bin_to_bcd4.sv | 23 ++
 rtl/display_formatter.sv | 147 ++++++++++++++
 tb/tb_display_formatter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Calculator-wide constants and types shared by the control FSM and display path.
package calc_pkg;

   localparam logic [1:0] OP_PLUS     = 2'd0;
   localparam logic [1:0] OP_MINUS    = 2'd1;
   localparam logic [1:0] OP_MULTIPLY = 2'd2;
   localparam logic [1:0] OP_DIVIDE   = 2'd3;

   localparam int unsigned SCALE        = 1000;
   localparam int unsigned MAX_DISP_INT = 9999;

   typedef logic [3:0] bcd_digit_t;

   // Integer and fractional parts of a display magnitude after saturation.
   typedef struct packed {
      logic [13:0] ip;
      logic [9:0]  fp;
   } disp_split_t;

endpackage

// File: rtl/bin_to_bcd4.sv
// Combinational 14-bit binary to 4-digit packed BCD converter (shift-and-add-3).
module bin_to_bcd4
   import calc_pkg::*;
(
   input  logic [13:0] bin,
   output logic [15:0] bcd
);

   logic [29:0] sr;

   always_comb begin
      sr = {16'd0, bin};
      for (int i = 0; i < 14; i++) begin
         for (int d = 0; d < 4; d++) begin
            if (sr[14 + 4*d +: 4] > 4'd4)
               sr[14 + 4*d +: 4] = sr[14 + 4*d +: 4] + 4'd3;
         end
         sr = sr << 1;
      end
      bcd = sr[29:14];
   end

endmodule

// File: rtl/display_formatter.sv
// Signed thousandths -> sign, decimal point and four BCD digits, two pipeline stages.
// Define SIGN_HINT_EN to show "-0" while the operand sign is minus and the value is zero.
module display_formatter
   import calc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [24:0] num,
   input  logic        [1:0]  sign,
   output logic               neg_display,
   output logic               frac_display,
   output logic        [1:0]  dp_pos,
   output logic        [15:0] num_display
);

   localparam logic [24:0] SCALE_W = 25'(SCALE);
   localparam logic [14:0] MAX_IP  = 15'(MAX_DISP_INT);

   function automatic disp_split_t saturate(input logic [14:0] ip, input logic [9:0] fp);
      disp_split_t r;
      if (ip > MAX_IP) begin
         r.ip = 14'(MAX_DISP_INT);
         r.fp = 10'd0;
      end else begin
         r.ip = ip[13:0];
         r.fp = fp;
      end
      return r;
   endfunction

   function automatic logic [2:0] digit_count(input logic [13:0] ip);
      if (ip >= 14'd1000)     return 3'd4;
      else if (ip >= 14'd100) return 3'd3;
      else if (ip >= 14'd10)  return 3'd2;
      else                    return 3'd1;
   endfunction

   // ---- stage 1: sign and magnitude ----
   logic        neg_p0;
   logic [24:0] abs_p0;
   logic        neg_p1;
   logic [24:0] abs_p1;

   always_comb begin
`ifdef SIGN_HINT_EN
      neg_p0 = num[24] | ((sign == OP_MINUS) && (num == 25'sd0));
`else
      neg_p0 = num[24];
`endif
      abs_p0 = num[24] ? $unsigned(-num) : $unsigned(num);
   end

`ifndef SIGN_HINT_EN
   logic unused_sign;
   assign unused_sign = ^sign;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_p1 <= 1'b0;
         abs_p1 <= '0;
      end else begin
         neg_p1 <= neg_p0;
         abs_p1 <= abs_p0;
      end
   end

   // ---- stage 2: split, saturate, BCD convert, select form ----
   logic [14:0]  ip_raw;
   logic [9:0]   fp_raw;
   disp_split_t  split_p1;
   logic [15:0]  ip_bcd;
   logic [15:0]  fp_bcd;
   logic [2:0]   k_p1;
   logic         frac_zero_p1;
   logic         frac_p1;
   logic [1:0]   dp_p1;
   logic [15:0]  disp_p1;

   assign ip_raw   = 15'(abs_p1 / SCALE_W);
   assign fp_raw   = 10'(abs_p1 % SCALE_W);
   assign split_p1 = saturate(ip_raw, fp_raw);
   assign k_p1     = digit_count(split_p1.ip);

   bin_to_bcd4 u_ip_bcd (
      .bin (split_p1.ip),
      .bcd (ip_bcd)
   );

   bin_to_bcd4 u_fp_bcd (
      .bin ({4'd0, split_p1.fp}),
      .bcd (fp_bcd)
   );

   // fp < 1000, so its thousands digit is always zero
   logic unused_fp_thousands;
   assign unused_fp_thousands = ^fp_bcd[15:12];

   always_comb begin
      case (k_p1)
         3'd1:    frac_zero_p1 = (fp_bcd[11:0] == 12'd0);
         3'd2:    frac_zero_p1 = (fp_bcd[11:4] == 8'd0);
         3'd3:    frac_zero_p1 = (fp_bcd[11:8] == 4'd0);
         default: frac_zero_p1 = 1'b1;
      endcase
   end

   always_comb begin
      frac_p1 = 1'b0;
      dp_p1   = 2'd0;
      disp_p1 = ip_bcd;
      if (!(k_p1 == 3'd4 || frac_zero_p1)) begin
         frac_p1 = 1'b1;
         dp_p1   = k_p1[1:0];
         case (k_p1)
            3'd1:    disp_p1 = {ip_bcd[3:0],  fp_bcd[11:0]};
            3'd2:    disp_p1 = {ip_bcd[7:0],  fp_bcd[11:4]};
            default: disp_p1 = {ip_bcd[11:0], fp_bcd[11:8]};
         endcase
      end
   end

   logic        neg_p2;
   logic        frac_p2;
   logic [1:0]  dp_p2;
   logic [15:0] disp_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_p2  <= 1'b0;
         frac_p2 <= 1'b0;
         dp_p2   <= 2'd0;
         disp_p2 <= 16'd0;
      end else begin
         neg_p2  <= neg_p1;
         frac_p2 <= frac_p1;
         dp_p2   <= dp_p1;
         disp_p2 <= disp_p1;
      end
   end

   assign neg_display  = neg_p2;
   assign frac_display = frac_p2;
   assign dp_pos       = dp_p2;
   assign num_display  = disp_p2;

endmodule

// File: tb/tb_display_formatter.sv
// Directed, table-driven bench for display_formatter (both SIGN_HINT_EN builds).
module tb_display_formatter;

   logic               clk;
   logic               rst_n;
   logic signed [24:0] num;
   logic        [1:0]  sign;
   logic               neg_display;
   logic               frac_display;
   logic        [1:0]  dp_pos;
   logic        [15:0] num_display;

   int checks = 0;
   int errors = 0;

   display_formatter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .num          (num),
      .sign         (sign),
      .neg_display  (neg_display),
      .frac_display (frac_display),
      .dp_pos       (dp_pos),
      .num_display  (num_display)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string              name;
      logic signed [24:0] num;
      logic        [1:0]  sign;
      logic               neg;
      logic               frac;
      logic        [1:0]  dp;
      logic        [15:0] disp;
   } vec_t;

`ifdef SIGN_HINT_EN
   localparam logic HINT_NEG = 1'b1;
`else
   localparam logic HINT_NEG = 1'b0;
`endif

   task automatic check_out(input string tag, input logic e_neg, input logic e_frac,
                            input logic [1:0] e_dp, input logic [15:0] e_disp);
      checks++;
      if (neg_display !== e_neg) begin
         errors++;
         $display("FAIL %s neg: got %b want %b", tag, neg_display, e_neg);
      end
      checks++;
      if (frac_display !== e_frac) begin
         errors++;
         $display("FAIL %s frac: got %b want %b", tag, frac_display, e_frac);
      end
      checks++;
      if (dp_pos !== e_dp) begin
         errors++;
         $display("FAIL %s dp_pos: got %0d want %0d", tag, dp_pos, e_dp);
      end
      checks++;
      if (num_display !== e_disp) begin
         errors++;
         $display("FAIL %s digits: got %h want %h", tag, num_display, e_disp);
      end
   endtask

   vec_t vecs[$];

   initial begin
      vecs.push_back('{"mixed_12345",   25'sd12345,     2'd0, 1'b0, 1'b1, 2'd2, 16'h1234});
      vecs.push_back('{"neg_int_5000",  -25'sd5000,     2'd0, 1'b1, 1'b0, 2'd0, 16'h0005});
      vecs.push_back('{"small_frac_1",  25'sd1,         2'd0, 1'b0, 1'b1, 2'd1, 16'h0001});
      vecs.push_back('{"int_9999000",   25'sd9999000,   2'd0, 1'b0, 1'b0, 2'd0, 16'h9999});
      vecs.push_back('{"sat_max_pos",   25'sd16777215,  2'd0, 1'b0, 1'b0, 2'd0, 16'h9999});
      vecs.push_back('{"sat_min_neg",   -25'sd16777216, 2'd0, 1'b1, 1'b0, 2'd0, 16'h9999});
      vecs.push_back('{"sat_10000000",  25'sd10000000,  2'd0, 1'b0, 1'b0, 2'd0, 16'h9999});
      vecs.push_back('{"k4_9999999",    25'sd9999999,   2'd0, 1'b0, 1'b0, 2'd0, 16'h9999});
      vecs.push_back('{"trunc_123456",  25'sd123456,    2'd0, 1'b0, 1'b1, 2'd3, 16'h1234});
      vecs.push_back('{"k3_zero_tenth", 25'sd100050,    2'd0, 1'b0, 1'b0, 2'd0, 16'h0100});
      vecs.push_back('{"k2_zero_frac",  25'sd10001,     2'd0, 1'b0, 1'b0, 2'd0, 16'h0010});
      vecs.push_back('{"k1_1050",       25'sd1050,      2'd0, 1'b0, 1'b1, 2'd1, 16'h1050});
      vecs.push_back('{"frac_only_999", 25'sd999,       2'd0, 1'b0, 1'b1, 2'd1, 16'h0999});
      vecs.push_back('{"neg_small_1",   -25'sd1,        2'd0, 1'b1, 1'b1, 2'd1, 16'h0001});
      vecs.push_back('{"neg_999999",    -25'sd999999,   2'd0, 1'b1, 1'b1, 2'd3, 16'h9999});
      vecs.push_back('{"zero_plus",     25'sd0,         2'd0, 1'b0, 1'b0, 2'd0, 16'h0000});
      vecs.push_back('{"zero_minus",    25'sd0,         2'd1, HINT_NEG, 1'b0, 2'd0, 16'h0000});
      vecs.push_back('{"zero_code3",    25'sd0,         2'd3, 1'b0, 1'b0, 2'd0, 16'h0000});
      vecs.push_back('{"minus_nonzero", 25'sd2000,      2'd1, 1'b0, 1'b0, 2'd0, 16'h0002});

      rst_n = 1'b0;
      num   = 25'sd4321;
      sign  = 2'd0;
      repeat (3) @(posedge clk);
      #1 check_out("reset_state", 1'b0, 1'b0, 2'd0, 16'h0000);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         num  = vecs[i].num;
         sign = vecs[i].sign;
         @(posedge clk);
         @(posedge clk);
         #1 check_out(vecs[i].name, vecs[i].neg, vecs[i].frac, vecs[i].dp, vecs[i].disp);
      end

      // back-to-back: one new value per cycle, two-cycle lag
      sign = 2'd0;
      num  = 25'sd1500;
      @(posedge clk); #1;
      num = -25'sd999999;
      @(posedge clk); #1;
      check_out("b2b_0", 1'b0, 1'b1, 2'd1, 16'h1500);
      num = 25'sd0;
      @(posedge clk); #1;
      check_out("b2b_1", 1'b1, 1'b1, 2'd3, 16'h9999);
      @(posedge clk); #1;
      check_out("b2b_2", 1'b0, 1'b0, 2'd0, 16'h0000);

      // reset mid-pipeline: in-flight values must vanish immediately
      num = -25'sd5000;
      @(posedge clk); #1;
      num = 25'sd12345;
      @(posedge clk); #1;
      check_out("pre_reset", 1'b1, 1'b0, 2'd0, 16'h0005);
      #3 rst_n = 1'b0;
      #1 check_out("async_reset", 1'b0, 1'b0, 2'd0, 16'h0000);
      @(posedge clk); #1;
      num = 25'sd1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_out("post_rel_1", 1'b0, 1'b0, 2'd0, 16'h0000);
      @(posedge clk); #1;
      check_out("post_rel_2", 1'b0, 1'b1, 2'd1, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
